// File: rtl/tpu_pkg.sv
// Shared TPU definitions: datapath widths used by the MAC cells
// and the weight feeder, plus the feeder's FSM state encoding.
package tpu_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;

    typedef enum logic [1:0] {
        WF_IDLE,
        WF_LOAD,
        WF_FULL
    } wf_state_t;

endpackage

// File: rtl/weight_feeder.sv
// Weight feeder: takes a tile as ROWS row beats over valid/ready,
// shifts it into the array's shadow weights, then issues one swap.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 sync abort of a partial/unswapped tile
//   in_valid/in_ready     row-beat handshake
//   in_data               row vector, column c at [8c+7:8c]
//   weight_col            to top-row cells' weight_in
//   load_weight           chain shifts one row this cycle
//   swap_weights          one-cycle pulse, cells swap buffers
//   swap_req              level request from the sequencer
//   tile_loaded           full tile waiting for swap
module weight_feeder
    import tpu_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COLS*DATA_W-1:0] in_data,
    output logic [COLS*DATA_W-1:0] weight_col,
    output logic                   load_weight,
    output logic                   swap_weights,
    input  logic                   swap_req,
    output logic                   tile_loaded
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS - 1);

    wf_state_t        state;
    wf_state_t        state_d;
    logic [CNT_W-1:0] row_cnt;
    logic [CNT_W-1:0] row_cnt_d;
    logic             run;
    logic             accept;
    logic             load_d;
    logic             swap_d;

    // run keeps in_ready low in the first cycle after reset,
    // so IDLE is effectively entered one cycle after release.
    assign in_ready    = run && (state != WF_FULL);
    assign tile_loaded = (state == WF_FULL);
    assign accept      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WF_IDLE;
            row_cnt      <= '0;
            run          <= 1'b0;
            load_weight  <= 1'b0;
            swap_weights <= 1'b0;
            weight_col   <= '0;
        end else begin
            state        <= state_d;
            row_cnt      <= row_cnt_d;
            run          <= 1'b1;
            load_weight  <= load_d;
            swap_weights <= swap_d;
            if (load_d) begin
                weight_col <= in_data;
            end
        end
    end

    always_comb begin
        state_d   = state;
        row_cnt_d = row_cnt;
        load_d    = 1'b0;
        swap_d    = 1'b0;
        if (clear) begin
            // An accept in this cycle is dropped on purpose.
            state_d   = WF_IDLE;
            row_cnt_d = '0;
        end else begin
            unique case (state)
                WF_IDLE, WF_LOAD: begin
                    if (accept) begin
                        load_d = 1'b1;
                        if (row_cnt == LAST) begin
                            state_d   = WF_FULL;
                            row_cnt_d = '0;
                        end else begin
                            state_d   = WF_LOAD;
                            row_cnt_d = row_cnt + 1'b1;
                        end
                    end
                end
                WF_FULL: begin
                    // Leaving FULL here makes the pulse single
                    // even if swap_req stays high.
                    if (swap_req) begin
                        swap_d  = 1'b1;
                        state_d = WF_IDLE;
                    end
                end
                default: begin
                    state_d   = WF_IDLE;
                    row_cnt_d = '0;
                end
            endcase
        end
    end

    // Swap is only issued from FULL, loads only from IDLE/LOAD.
    swap_load_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(load_weight && swap_weights)
    );

endmodule

// File: tb/tb_weight_feeder.sv
// Self-checking bench for weight_feeder: directed vector table,
// hand-written corner sequences and a randomized run.
module tb_weight_feeder;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = COLS * 8;

    localparam logic [W-1:0] TA = 32'h04030201;
    localparam logic [W-1:0] TB = 32'h08070605;
    localparam logic [W-1:0] TC = 32'h0C0B0A09;
    localparam logic [W-1:0] TD = 32'h100F0E0D;
    localparam logic [W-1:0] TE = 32'h14131211;
    localparam logic [W-1:0] TF = 32'h18171615;
    localparam logic [W-1:0] TG = 32'h1C1B1A19;
    localparam logic [W-1:0] TH = 32'h201F1E1D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         swap_req = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         load_weight;
    logic         swap_weights;
    logic         tile_loaded;
    logic [W-1:0] weight_col;

    weight_feeder #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .weight_col  (weight_col),
        .load_weight (load_weight),
        .swap_weights(swap_weights),
        .swap_req    (swap_req),
        .tile_loaded (tile_loaded)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Tile-level reference model.
    bit           m_run;
    bit           m_full;
    bit           m_load;
    bit           m_swap;
    logic [W-1:0] m_col;
    logic [W-1:0] partial[$];
    logic [W-1:0] last_tile[ROWS];

    // Downstream array: shadow chain and active weights.
    logic [W-1:0] shadow[ROWS];
    logic [W-1:0] active[ROWS];
    int           swaps_seen;
    int           loads_seen;

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           sr;
        bit           clr;
        bit           e_rdy;
        bit           e_ld;
        logic [W-1:0] e_col;
        bit           e_sw;
        bit           e_tl;
    } vec_t;

    vec_t vt[10];

    task automatic check_b(input string name, input bit act, input bit exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_full = 0;
        m_load = 0;
        m_swap = 0;
        m_col  = '0;
        partial.delete();
        for (int r = 0; r < ROWS; r++) begin
            shadow[r] = '0;
            active[r] = '0;
        end
    endtask

    // Advance the model by one clock given the inputs of this cycle.
    task automatic model_step(input bit v, input logic [W-1:0] d,
                              input bit sr, input bit clr);
        bit acc;
        acc    = v && m_run && !m_full;
        m_load = 0;
        m_swap = 0;
        if (clr) begin
            m_full = 0;
            partial.delete();
        end else if (m_full && sr) begin
            m_swap = 1;
            m_full = 0;
        end else if (acc) begin
            m_load = 1;
            m_col  = d;
            partial.push_back(d);
            if (partial.size() == ROWS) begin
                for (int k = 0; k < ROWS; k++) last_tile[k] = partial[k];
                partial.delete();
                m_full = 1;
            end
        end
        m_run = 1;
    endtask

    task automatic compare_outputs();
        check_b("in_ready", in_ready, m_run && !m_full);
        check_b("load_weight", load_weight, m_load);
        check_b("swap_weights", swap_weights, m_swap);
        check_b("tile_loaded", tile_loaded, m_full);
        check_w("weight_col", weight_col, m_col);
    endtask

    task automatic array_update();
        if (swap_weights) begin
            swaps_seen++;
            for (int r = 0; r < ROWS; r++) active[r] = shadow[r];
            for (int k = 0; k < ROWS; k++)
                check_w("swap_row", active[ROWS-1-k], last_tile[k]);
        end
        if (load_weight) begin
            loads_seen++;
            for (int r = ROWS - 1; r > 0; r--) shadow[r] = shadow[r-1];
            shadow[0] = weight_col;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        array_update();
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d,
                         input bit sr, input bit clr);
        in_valid = v;
        in_data  = d;
        swap_req = sr;
        clear    = clr;
        model_step(v, d, sr, clr);
    endtask

    task automatic cyc(input bit v, input logic [W-1:0] d,
                       input bit sr, input bit clr);
        tick();
        drive(v, d, sr, clr);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_b({tag, "_ready"}, in_ready, 1'b0);
        check_b({tag, "_load"}, load_weight, 1'b0);
        check_b({tag, "_swap"}, swap_weights, 1'b0);
        check_b({tag, "_tl"}, tile_loaded, 1'b0);
        check_w({tag, "_col"}, weight_col, '0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 0;
        in_data = '0;
        swap_req = 0;
        clear = 0;
        model_reset();
        model_step(0, '0, 0, 0);
    endtask

    initial begin
        int base;
        bit sr;

        vt[0] = '{1, TA, 0, 0, 1, 0, '0, 0, 0};
        vt[1] = '{1, TB, 0, 0, 1, 1, TA, 0, 0};
        vt[2] = '{1, TC, 0, 0, 1, 1, TB, 0, 0};
        vt[3] = '{1, TD, 0, 0, 1, 1, TC, 0, 0};
        vt[4] = '{0, '0, 1, 0, 0, 1, TD, 0, 1};
        vt[5] = '{0, '0, 1, 0, 1, 0, TD, 1, 0};
        vt[6] = '{0, '0, 1, 0, 1, 0, TD, 0, 0};
        vt[7] = '{0, '0, 1, 0, 1, 0, TD, 0, 0};
        vt[8] = '{0, '0, 1, 0, 1, 0, TD, 0, 0};
        vt[9] = '{0, '0, 0, 0, 1, 0, TD, 0, 0};

        swaps_seen = 0;
        loads_seen = 0;
        model_reset();

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clk);
        check_reset_outputs("reset_hold");
        release_reset();
        tick();
        // First cycle after reset release: in_ready just came up.

        // Plan 1 + 3: back-to-back tile, then held swap request.
        base = swaps_seen;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            check_b("vec_ready", in_ready, vt[i].e_rdy);
            check_b("vec_load", load_weight, vt[i].e_ld);
            check_w("vec_col", weight_col, vt[i].e_col);
            check_b("vec_swap", swap_weights, vt[i].e_sw);
            check_b("vec_tl", tile_loaded, vt[i].e_tl);
            drive(vt[i].v, vt[i].d, vt[i].sr, vt[i].clr);
        end
        tick();
        drive(0, '0, 0, 0);
        check_i("plan3_one_swap", swaps_seen - base, 1);
        check_w("plan1_active_r3", active[3], TA);
        check_w("plan1_active_r0", active[0], TD);

        // Plan 2: bubbles between beats 1 and 2.
        base = loads_seen;
        cyc(1, TA, 0, 0);
        cyc(1, TB, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(1, TC, 0, 0);
        cyc(1, TD, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        check_i("plan2_loads", loads_seen - base, 4);
        check_w("plan2_shadow_r3", shadow[3], TA);
        check_w("plan2_shadow_r0", shadow[0], TD);
        check_b("plan2_tl", tile_loaded, 1'b1);

        // Plan 4: second tile offered while FULL.
        base = loads_seen;
        cyc(1, TE, 0, 0);
        cyc(1, TE, 0, 0);
        cyc(1, TE, 0, 0);
        check_i("plan4_stalled", loads_seen - base, 0);
        cyc(1, TE, 1, 0);
        cyc(1, TE, 0, 0);
        cyc(1, TF, 0, 0);
        cyc(1, TG, 0, 0);
        cyc(1, TH, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        check_w("plan4_active_r3", active[3], TA);
        check_w("plan4_active_r0", active[0], TD);
        check_w("plan4_shadow_r3", shadow[3], TE);
        check_w("plan4_shadow_r0", shadow[0], TH);
        check_b("plan4_tl", tile_loaded, 1'b1);

        // Plan 5: swap request during LOAD.
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        tick();
        base = swaps_seen;
        drive(1, TA, 0, 0);
        cyc(1, TB, 0, 0);
        cyc(1, TC, 1, 0);
        cyc(1, TD, 1, 0);
        check_i("plan5_no_early_swap", swaps_seen - base, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        check_i("plan5_one_swap", swaps_seen - base, 1);

        // Plan 6a: clear after 3 beats (accept in clear cycle dropped).
        cyc(1, TA, 0, 0);
        cyc(1, TB, 0, 0);
        cyc(1, TC, 0, 0);
        cyc(1, TD, 0, 1);
        cyc(1, TE, 0, 0);
        cyc(1, TF, 0, 0);
        cyc(1, TG, 0, 0);
        cyc(0, '0, 0, 0);
        check_b("plan6_not_loaded", tile_loaded, 1'b0);
        cyc(1, TH, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        check_b("plan6_loaded", tile_loaded, 1'b1);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        check_w("plan6_active_r3", active[3], TE);

        // Plan 6b: async reset in the middle of LOAD.
        cyc(1, TA, 0, 0);
        cyc(1, TB, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        release_reset();
        cyc(0, '0, 0, 0);
        cyc(1, TE, 0, 0);
        cyc(1, TF, 0, 0);
        cyc(1, TG, 0, 0);
        cyc(0, '0, 0, 0);
        check_b("midrst_partial", tile_loaded, 1'b0);
        cyc(1, TH, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        check_b("midrst_full", tile_loaded, 1'b1);
        check_w("midrst_shadow_r3", shadow[3], TE);

        // Randomized traffic against the model.
        sr = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (swap_weights) sr = 0;
            else if (!sr && ($urandom_range(0, 7) == 0)) sr = 1;
            drive(($urandom_range(0, 9) < 7), W'($urandom), sr,
                  ($urandom_range(0, 49) == 0));
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
